// File: rtl/word_scroll_ctrl_if.sv
// Host-side bundle for the scrolling word controller: word-store writes,
// run control pulses and the three character codes plus status it returns.
interface word_scroll_ctrl_if;
    logic       Wr;
    logic [2:0] WrAddr;
    logic [1:0] WrData;
    logic [2:0] Len;
    logic       Start;
    logic       Stop;
    logic       Step;
    logic       Dir;
    logic [1:0] Char2;
    logic [1:0] Char1;
    logic [1:0] Char0;
    logic [2:0] Pos;
    logic       Running;
    logic       Tick;

    modport master (
        output Wr, WrAddr, WrData, Len, Start, Stop, Step, Dir,
        input  Char2, Char1, Char0, Pos, Running, Tick
    );

    modport slave (
        input  Wr, WrAddr, WrData, Len, Start, Stop, Step, Dir,
        output Char2, Char1, Char0, Pos, Running, Tick
    );
endinterface

// File: rtl/word_scroll_ctrl.sv
// Scroll controller for the three-digit character display. Holds an 8-slot
// word of 2-bit codes, rotates a head index either on a prescaled timer (RUN)
// or on manual steps (HALT), and presents three consecutive characters.
module word_scroll_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DEPTH    = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    word_scroll_ctrl_if.slave bus
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);

    typedef enum logic {ST_HALT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pos_q, pos_d;
    logic [2:0]       len_q, len_d;      // word length minus one
    logic             running_q, running_d;
    logic             tick_q, tick_d;
    logic [1:0]       char2_q, char2_d;
    logic [1:0]       char1_q, char1_d;
    logic [1:0]       char0_q, char0_d;
    logic [1:0]       mem_q [DEPTH];
    logic [1:0]       mem_d [DEPTH];

    logic             start_ok;
    logic             advance;
    logic [3:0]       len_full;
    logic [3:0]       idx1_raw, idx2_raw, idx1_sub, idx2_sub;
    logic [2:0]       idx1, idx2;

    // Word store: each slot is an independent register, writable in any state.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_comb begin
            mem_d[gi] = mem_q[gi];
            if (bus.Wr && (bus.WrAddr == 3'(gi)))
                mem_d[gi] = bus.WrData;
        end

        always_ff @(posedge Clock) begin
            if (Reset) mem_q[gi] <= 2'b11;
            else       mem_q[gi] <= mem_d[gi];
        end
    end

    // Next state, prescaler and head position; Stop overrides a coincident Start.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        len_d    = len_q;
        advance  = 1'b0;
        start_ok = bus.Start & ~bus.Stop;
        case (state_q)
            ST_HALT: begin
                cnt_d = '0;
                if (start_ok) begin
                    state_d = ST_RUN;
                    len_d   = bus.Len;
                    pos_d   = 3'd0;
                end else if (bus.Step) begin
                    advance = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.Stop) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end else if (bus.Start) begin
                    len_d = bus.Len;
                    pos_d = 3'd0;
                    cnt_d = '0;
                end else if (cnt_q == CNT_TERM) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase
        if (advance) begin
            if (bus.Dir) pos_d = (pos_q == 3'd0)  ? len_q : pos_q - 3'd1;
            else         pos_d = (pos_q == len_q) ? 3'd0  : pos_q + 3'd1;
        end
        running_d = (state_d == ST_RUN);
        tick_d    = advance;
    end

    // Neighbour indices wrap modulo L by compare-and-subtract; pos < L always holds.
    always_comb begin
        len_full = {1'b0, len_q} + 4'd1;
        idx1_raw = {1'b0, pos_q} + 4'd1;
        idx1_sub = idx1_raw - len_full;
        idx1     = (idx1_raw >= len_full) ? idx1_sub[2:0] : idx1_raw[2:0];
        idx2_raw = {1'b0, idx1} + 4'd1;
        idx2_sub = idx2_raw - len_full;
        idx2     = (idx2_raw >= len_full) ? idx2_sub[2:0] : idx2_raw[2:0];
        char2_d  = mem_q[pos_q];
        char1_d  = mem_q[idx1];
        char0_d  = mem_q[idx2];
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_HALT;
            cnt_q     <= '0;
            pos_q     <= 3'd0;
            len_q     <= 3'd2;
            running_q <= 1'b0;
            tick_q    <= 1'b0;
            char2_q   <= 2'b11;
            char1_q   <= 2'b11;
            char0_q   <= 2'b11;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pos_q     <= pos_d;
            len_q     <= len_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            char2_q   <= char2_d;
            char1_q   <= char1_d;
            char0_q   <= char0_d;
        end
    end

    assign bus.Char2   = char2_q;
    assign bus.Char1   = char1_q;
    assign bus.Char0   = char0_q;
    assign bus.Pos     = pos_q;
    assign bus.Running = running_q;
    assign bus.Tick    = tick_q;
endmodule

// File: tb/tb_word_scroll_ctrl.sv
// Bench for word_scroll_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the scroll rules.
module tb_word_scroll_ctrl;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    word_scroll_ctrl_if bus();

    word_scroll_ctrl #(.TICK_DIV(TD), .DEPTH(8)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: values the DUT outputs should hold after the last edge.
    int m_run, m_pos, m_L, m_tick, m_c2, m_c1, m_c0;
    int m_mem [8];
    int cyc = 0;
    int deadline = 0;
    bit checking = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Apply the effect of one rising edge with the currently driven inputs.
    task automatic model_edge();
        int npos, nL, nrun, adv;
        if (rst) begin
            m_run = 0; m_pos = 0; m_L = 3; m_tick = 0;
            m_c2 = 3; m_c1 = 3; m_c0 = 3;
            for (int i = 0; i < 8; i++) m_mem[i] = 3;
        end else begin
            m_c2 = m_mem[m_pos];
            m_c1 = m_mem[(m_pos + 1) % m_L];
            m_c0 = m_mem[(m_pos + 2) % m_L];
            npos = m_pos; nL = m_L; nrun = m_run; adv = 0;
            if (m_run != 0) begin
                if (bus.Stop) nrun = 0;
                else if (bus.Start) begin
                    nL = int'(bus.Len) + 1; npos = 0; deadline = cyc + TD;
                end else if (cyc == deadline) begin
                    adv = 1; deadline = cyc + TD;
                end
            end else begin
                if (bus.Start && !bus.Stop) begin
                    nrun = 1; nL = int'(bus.Len) + 1; npos = 0; deadline = cyc + TD;
                end else if (bus.Step) adv = 1;
            end
            if (adv != 0)
                npos = bus.Dir ? (m_pos + m_L - 1) % m_L : (m_pos + 1) % m_L;
            if (bus.Wr) m_mem[bus.WrAddr] = int'(bus.WrData);
            m_pos = npos; m_L = nL; m_run = nrun; m_tick = adv;
        end
        cyc++;
    endtask

    // One clock: model the edge, let the DUT take it, compare on the falling edge.
    task automatic clock_once();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (checking) begin
            chk("char2",   int'(bus.Char2),   m_c2);
            chk("char1",   int'(bus.Char1),   m_c1);
            chk("char0",   int'(bus.Char0),   m_c0);
            chk("pos",     int'(bus.Pos),     m_pos);
            chk("running", int'(bus.Running), m_run);
            chk("tick",    int'(bus.Tick),    m_tick);
        end
        rst = 1'b0; bus.Wr = 1'b0; bus.Start = 1'b0; bus.Stop = 1'b0; bus.Step = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clock_once();
    endtask

    initial begin
        bus.Wr = 1'b0; bus.WrAddr = 3'd0; bus.WrData = 2'd0; bus.Len = 3'd0;
        bus.Start = 1'b0; bus.Stop = 1'b0; bus.Step = 1'b0; bus.Dir = 1'b0;
        @(negedge clk);
        checking = 1'b1;

        // Reset held two cycles
        rst = 1'b1; clock_once();
        rst = 1'b1; clock_once();
        $display("phase reset: pos=%0d running=%0d", bus.Pos, bus.Running);

        // Load 00,01,10,10 and run left with L=4
        for (int i = 0; i < 4; i++) begin
            bus.Wr = 1'b1; bus.WrAddr = 3'(i); bus.WrData = (i == 0) ? 2'd0 : (i == 1) ? 2'd1 : 2'd2;
            clock_once();
        end
        bus.Len = 3'd3; bus.Dir = 1'b0; bus.Start = 1'b1; clock_once();
        bus.Len = 3'd6; idle(18);
        $display("phase run-left: pos=%0d", bus.Pos);

        // Right scroll
        bus.Dir = 1'b1; idle(10);
        $display("phase run-right: pos=%0d", bus.Pos);

        // Stop, then manual steps, then a step in RUN
        bus.Stop = 1'b1; clock_once(); idle(6);
        for (int i = 0; i < 3; i++) begin bus.Step = 1'b1; clock_once(); idle(1); end
        bus.Dir = 1'b0; bus.Len = 3'd3; bus.Start = 1'b1; clock_once();
        idle(1); bus.Step = 1'b1; clock_once(); idle(4);
        $display("phase stop-step: pos=%0d", bus.Pos);

        // L=1 with mem[0]=01
        bus.Wr = 1'b1; bus.WrAddr = 3'd0; bus.WrData = 2'd1; clock_once();
        bus.Len = 3'd0; bus.Start = 1'b1; clock_once(); idle(10);
        $display("phase len1: char2=%0d pos=%0d", bus.Char2, bus.Pos);

        // Stop on the terminal-count edge
        bus.Len = 3'd3; bus.Start = 1'b1; clock_once(); idle(3);
        bus.Stop = 1'b1; clock_once(); idle(4);
        // Start together with Stop, and Start together with Step
        bus.Start = 1'b1; bus.Stop = 1'b1; clock_once(); idle(2);
        bus.Start = 1'b1; bus.Step = 1'b1; bus.Len = 3'd1; clock_once(); idle(6);
        // Reset mid-RUN
        rst = 1'b1; clock_once(); idle(2);
        $display("phase collisions: running=%0d", bus.Running);

        // Live write of the head slot during RUN
        bus.Len = 3'd4; bus.Start = 1'b1; clock_once(); idle(5);
        bus.Wr = 1'b1; bus.WrAddr = 3'(m_pos); bus.WrData = 2'd3; clock_once(); idle(10);
        $display("phase live-write: pos=%0d", bus.Pos);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            bus.Wr    = ($urandom_range(0, 3) == 0);
            bus.WrAddr = 3'($urandom_range(0, 7));
            bus.WrData = 2'($urandom_range(0, 3));
            bus.Len   = 3'($urandom_range(0, 7));
            bus.Dir   = ($urandom_range(0, 5) == 0) ? ~bus.Dir : bus.Dir;
            bus.Start = ($urandom_range(0, 39) == 0);
            bus.Stop  = ($urandom_range(0, 39) == 0);
            bus.Step  = ($urandom_range(0, 5) == 0) && !bus.Stop;
            clock_once();
        end
        $display("phase random: cycles=%0d", cyc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
